// File: rtl/store_buffer_dual.sv
// store_buffer_dual
//
// Purpose: dual-lane store buffer and load initiator for a two-port,
// byte-addressed data cache. Up to two stores and two loads arrive per cycle.
// Stores are queued in program order in a circular FIFO. They drain onto any
// cache port that this cycle's loads leave unused. Load data is registered
// one cycle after issue.
//
// Build option: STORE_FORWARD_EN
//   defined   - loads are always accepted. Data from the youngest matching
//               buffered store overrides the cache read data.
//   undefined - a load whose word address matches any buffered store is
//               refused (ldReady low). The requester retries. Load data
//               always comes from the cache.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_stValid0/1, i_stAddr0/1,
//   i_stData0/1                 store requests; lane 0 is older than lane 1
//   o_stReady                   both store lanes may enqueue this cycle
//   i_ldValid0/1, i_ldAddr0/1   load requests; lane 0 uses cache port 1,
//                               lane 1 uses cache port 2
//   o_ldReady0/1                load lane accepted this cycle
//   o_ldDataValid0/1,
//   o_ldData0/1                 registered load results
//   o_sbEmpty                   no buffered stores (fence support)
//   o_writeEn1/2, o_addr1/2,
//   o_writeData1/2              cache port controls; the cache writes on
//                               the falling edge of the same cycle
//   i_readData1/2               combinational cache read data per port

module store_buffer_dual #(
  parameter int dataSize = 32,
  parameter int addrSize = 32,
  parameter int sbDepth  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stValid0,
  input  logic                i_stValid1,
  input  logic [addrSize-1:0] i_stAddr0,
  input  logic [addrSize-1:0] i_stAddr1,
  input  logic [dataSize-1:0] i_stData0,
  input  logic [dataSize-1:0] i_stData1,
  output logic                o_stReady,
  input  logic                i_ldValid0,
  input  logic                i_ldValid1,
  input  logic [addrSize-1:0] i_ldAddr0,
  input  logic [addrSize-1:0] i_ldAddr1,
  output logic                o_ldReady0,
  output logic                o_ldReady1,
  output logic                o_ldDataValid0,
  output logic                o_ldDataValid1,
  output logic [dataSize-1:0] o_ldData0,
  output logic [dataSize-1:0] o_ldData1,
  output logic                o_sbEmpty,
  output logic                o_writeEn1,
  output logic                o_writeEn2,
  output logic [addrSize-1:0] o_addr1,
  output logic [addrSize-1:0] o_addr2,
  output logic [dataSize-1:0] o_writeData1,
  output logic [dataSize-1:0] o_writeData2,
  input  logic [dataSize-1:0] i_readData1,
  input  logic [dataSize-1:0] i_readData2
);

  localparam int ptrW = $clog2(sbDepth);
  localparam int cntW = ptrW + 1;
  localparam logic [cntW-1:0] readyLimit = cntW'(sbDepth - 2);

  // Buffer storage and FIFO bookkeeping
  logic [addrSize-1:0] r_addr [sbDepth];
  logic [dataSize-1:0] r_data [sbDepth];
  logic [ptrW-1:0]     r_rdPtr;
  logic [ptrW-1:0]     r_wrPtr;
  logic [cntW-1:0]     r_count;

  // Registered load results
  logic                r_ldDataValid0;
  logic                r_ldDataValid1;
  logic [dataSize-1:0] r_ldData0;
  logic [dataSize-1:0] r_ldData1;

  // Enqueue side
  logic                w_stReady;
  logic                w_enq0;
  logic                w_enq1;
  logic [1:0]          w_enqCnt;
  logic [ptrW-1:0]     w_lane1Idx;

  // Load side
  logic                w_hit0;
  logic                w_hit1;
  logic                w_ldReady0;
  logic                w_ldReady1;
  logic                w_ldAcc0;
  logic                w_ldAcc1;
  logic [dataSize-1:0] w_ldResult0;
  logic [dataSize-1:0] w_ldResult1;
`ifdef STORE_FORWARD_EN
  logic [dataSize-1:0] w_fwdData0;
  logic [dataSize-1:0] w_fwdData1;
`endif

  // Drain side
  logic [1:0]          w_freePorts;
  logic [1:0]          w_drainCnt;
  logic [ptrW-1:0]     w_oldIdx;
  logic [ptrW-1:0]     w_nextIdx;
  logic                w_writeEn1;
  logic                w_writeEn2;
  logic [addrSize-1:0] w_addr1;
  logic [addrSize-1:0] w_addr2;
  logic [dataSize-1:0] w_writeData1;
  logic [dataSize-1:0] w_writeData2;

  // Room for two is judged on the registered count alone, so the
  // enqueue decision never depends on how many entries drain this cycle.
  assign w_stReady  = (r_count <= readyLimit);
  assign w_enq0     = w_stReady & i_stValid0;
  assign w_enq1     = w_stReady & i_stValid1;
  assign w_enqCnt   = {1'b0, w_enq0} + {1'b0, w_enq1};
  // Lane 1 takes the slot after lane 0, or lane 0's slot if lane 0 is idle.
  assign w_lane1Idx = w_enq0 ? (r_wrPtr + ptrW'(1)) : r_wrPtr;

  // Scan valid entries from oldest to youngest; later hits overwrite earlier
  // ones, so the surviving forward data belongs to the youngest match.
  always_comb begin
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
`ifdef STORE_FORWARD_EN
    w_fwdData0 = '0;
    w_fwdData1 = '0;
`endif
    for (int i = 0; i < sbDepth; i++) begin
      if (cntW'(i) < r_count) begin
        if (r_addr[r_rdPtr + ptrW'(i)][addrSize-1:2] == i_ldAddr0[addrSize-1:2]) begin
          w_hit0 = 1'b1;
`ifdef STORE_FORWARD_EN
          w_fwdData0 = r_data[r_rdPtr + ptrW'(i)];
`endif
        end
        if (r_addr[r_rdPtr + ptrW'(i)][addrSize-1:2] == i_ldAddr1[addrSize-1:2]) begin
          w_hit1 = 1'b1;
`ifdef STORE_FORWARD_EN
          w_fwdData1 = r_data[r_rdPtr + ptrW'(i)];
`endif
        end
      end
    end
  end

`ifdef STORE_FORWARD_EN
  assign w_ldReady0  = 1'b1;
  assign w_ldReady1  = 1'b1;
  assign w_ldResult0 = w_hit0 ? w_fwdData0 : i_readData1;
  assign w_ldResult1 = w_hit1 ? w_fwdData1 : i_readData2;
`else
  // Without forwarding, a load must wait until every matching store has
  // reached the cache, so the cache data is then always current.
  assign w_ldReady0  = ~w_hit0;
  assign w_ldReady1  = ~w_hit1;
  assign w_ldResult0 = i_readData1;
  assign w_ldResult1 = i_readData2;
`endif

  assign w_ldAcc0 = i_ldValid0 & w_ldReady0;
  assign w_ldAcc1 = i_ldValid1 & w_ldReady1;

  // Drain as many oldest entries as there are ports left unused by loads.
  always_comb begin
    w_freePorts = {1'b0, ~w_ldAcc0} + {1'b0, ~w_ldAcc1};
    if (r_count >= cntW'(2)) begin
      w_drainCnt = w_freePorts;
    end else if (r_count == cntW'(1)) begin
      w_drainCnt = (w_freePorts != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      w_drainCnt = 2'd0;
    end
  end

  assign w_oldIdx  = r_rdPtr;
  assign w_nextIdx = r_rdPtr + ptrW'(1);

  // Port steering. Two drains: oldest on port 1, next on port 2, so the
  // younger write lands on the port the cache lets win on an address clash.
  // One drain: oldest goes to the lowest-numbered free port.
  always_comb begin
    w_writeEn1   = 1'b0;
    w_writeEn2   = 1'b0;
    w_addr1      = '0;
    w_addr2      = '0;
    w_writeData1 = '0;
    w_writeData2 = '0;
    if (w_ldAcc0) begin
      w_addr1 = i_ldAddr0;
    end
    if (w_ldAcc1) begin
      w_addr2 = i_ldAddr1;
    end
    case (w_drainCnt)
      2'd2: begin
        w_writeEn1   = 1'b1;
        w_addr1      = r_addr[w_oldIdx];
        w_writeData1 = r_data[w_oldIdx];
        w_writeEn2   = 1'b1;
        w_addr2      = r_addr[w_nextIdx];
        w_writeData2 = r_data[w_nextIdx];
      end
      2'd1: begin
        if (!w_ldAcc0) begin
          w_writeEn1   = 1'b1;
          w_addr1      = r_addr[w_oldIdx];
          w_writeData1 = r_data[w_oldIdx];
        end else begin
          w_writeEn2   = 1'b1;
          w_addr2      = r_addr[w_oldIdx];
          w_writeData2 = r_data[w_oldIdx];
        end
      end
      default: begin
      end
    endcase
  end

  // Pointers and occupancy. Reset empties the buffer, which also stops any
  // further drain because drains are gated by the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      r_rdPtr <= r_rdPtr + ptrW'(w_drainCnt);
      r_wrPtr <= r_wrPtr + ptrW'(w_enqCnt);
      r_count <= r_count + cntW'(w_enqCnt) - cntW'(w_drainCnt);
    end
  end

  // Entry payloads need no reset; validity is defined by the count.
  always_ff @(posedge clk) begin
    if (w_enq0) begin
      r_addr[r_wrPtr] <= i_stAddr0;
      r_data[r_wrPtr] <= i_stData0;
    end
    if (w_enq1) begin
      r_addr[w_lane1Idx] <= i_stAddr1;
      r_data[w_lane1Idx] <= i_stData1;
    end
  end

  // Load results: valid for exactly the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ldDataValid0 <= 1'b0;
      r_ldDataValid1 <= 1'b0;
      r_ldData0      <= '0;
      r_ldData1      <= '0;
    end else begin
      r_ldDataValid0 <= w_ldAcc0;
      r_ldDataValid1 <= w_ldAcc1;
      if (w_ldAcc0) begin
        r_ldData0 <= w_ldResult0;
      end
      if (w_ldAcc1) begin
        r_ldData1 <= w_ldResult1;
      end
    end
  end

  assign o_stReady      = w_stReady;
  assign o_sbEmpty      = (r_count == '0);
  assign o_ldReady0     = w_ldReady0;
  assign o_ldReady1     = w_ldReady1;
  assign o_ldDataValid0 = r_ldDataValid0;
  assign o_ldDataValid1 = r_ldDataValid1;
  assign o_ldData0      = r_ldData0;
  assign o_ldData1      = r_ldData1;
  assign o_writeEn1     = w_writeEn1;
  assign o_writeEn2     = w_writeEn2;
  assign o_addr1        = w_addr1;
  assign o_addr2        = w_addr2;
  assign o_writeData1   = w_writeData1;
  assign o_writeData2   = w_writeData2;

endmodule

// File: doc/store_buffer_dual.md
# store_buffer_dual

Dual-lane store buffer and load initiator driving both ports of the two-port byte-addressed data cache. Accepts up to two stores and two loads per cycle from the superscalar memory stage. Queues stores in program order and drains them onto cache ports that loads leave free. Returns load data one cycle after issue, forwarding from buffered stores so loads never see stale memory.

## Interface
- dataSize, 32, data word width in bits
- addrSize, 32, byte address width
- sbDepth, 8, store buffer entries; power of two, ≥4
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- stValid0, stValid1  in  1  store request per lane; lane 0 older than lane 1
- stAddr0, stAddr1  in  addrSize  store byte address, word aligned (bits [1:0] = 0)
- stData0, stData1  in  dataSize  store data
- stReady  out  1  both lanes may enqueue this cycle
- ldValid0, ldValid1  in  1  load request per lane
- ldAddr0, ldAddr1  in  addrSize  load byte address, word aligned
- ldReady0, ldReady1  out  1  load lane accepted this cycle
- ldDataValid0, ldDataValid1  out  1  load result valid
- ldData0, ldData1  out  dataSize  load result
- sbEmpty  out  1  no buffered stores; used for fences
- writeEn1, writeEn2  out  1  cache write enables
- addr1, addr2  out  addrSize  cache port addresses
- writeData1, writeData2  out  dataSize  cache write data
- readData1, readData2  in  dataSize  cache combinational read data

## Operation
- Buffer is a circular FIFO: rdPtr, wrPtr (log2(sbDepth) bits, wrap modulo sbDepth), count (log2(sbDepth)+1 bits).
- stReady = (count ≤ sbDepth−2), based on registered count only.
- Enqueue when stReady: stValid0 and stValid1 each enqueue one entry. Lane 0 is written before lane 1. If only lane 1 is valid, it takes the single slot.
- Port ownership per cycle: an accepted ldValid0 drives addr1; an accepted ldValid1 drives addr2. Ports not used by loads are free for draining.
- Drain takes min(free ports, count) oldest entries.
  - With two drains, the oldest goes to port 1 and the next to port 2.
  - With one drain, the oldest goes to the lowest-numbered free port.
- Drained entries pop at posedge. Cache write occurs at the negedge of the same cycle.
- Port 2 is always the younger write, which matches the cache's same-address rule (port 2 wins).
- Same-cycle ordering: loads are older than stores enqueued in that cycle, so no forwarding from incoming stores.
- Load result is registered at posedge:
  - ldData = youngest valid buffer entry whose addr[addrSize−1:2] matches, if any;
  - otherwise the cache readData of that lane's port.
- Count update: count_next = count + enq − drain, with enq and drain each in 0..2.
- Idle ports drive writeEn = 0 and addr = 0.

## Timing
- Reset (async, immediate): count = 0, pointers = 0, sbEmpty = 1, stReady = 1, ldDataValid0/1 = 0, ldData0/1 = 0, writeEn1/2 = 0.
- Load latency is 1 cycle: accepted at cycle N, ldDataValid high for exactly cycle N+1.
- Store-to-cache latency is ≥1 cycle: a store enqueued at N drains no earlier than N+1.
- Full: with count = sbDepth−1, stReady = 0 and stores are held. Drains continue.
- Empty: both ports go to loads or idle. sbEmpty = (count == 0).
- Wrap-around: pointer increments modulo sbDepth. A two-entry enqueue or drain that straddles the wrap splits across index sbDepth−1 and index 0.
- A store draining in the same cycle as a same-address load on the other port returns the new data, from both the forward path and the cache.
- Reset mid-operation discards all buffered stores. No cache write occurs after rst asserts.

## Configuration
- STORE_FORWARD_EN defined:
  - forwarding is active as described;
  - ldReady0 = ldReady1 = 1 always.
- STORE_FORWARD_EN undefined:
  - no forward mux;
  - ldReadyX = 0 while ldAddrX word-matches any valid buffer entry, and the load is not issued that cycle;
  - the pipeline retries, and the load issues once the entry drains; ldData always comes from the cache.

## Test plan
- Reset then two stores per cycle for 4 cycles with no loads (addr 0x00..0x1C, data 0xA0..0xA7) -> stReady stays 1. Entries drain two per cycle in order, 0xA0 on port 1 and 0xA1 on port 2. sbEmpty = 1 at cycle 5.
- Loads on both lanes every cycle while 7 stores are enqueued -> count reaches 7 and stReady = 0. No writeEn asserts. Drain resumes the cycle after loads stop.
- Store 0x11111111 then 0x22222222 to 0x40 in one cycle, load 0x40 the next cycle -> ldData0 = 0x22222222 at N+1 (forward build); ldReady0 = 0 until drained (non-forward build).
- Load on lane 0 only, 3 stores buffered -> oldest drains on port 2, and the cache read on port 1 returns the correct word.
- Fill to wrap (pointer 7 -> 0) with a two-entry enqueue and a two-entry drain in the same cycle -> count unchanged, FIFO order preserved.
- Assert rst with 5 entries buffered -> writeEn1/2 = 0 immediately, sbEmpty = 1, and no later cache write.
